// File: rtl/basic_computer_pkg.sv
// Shared encodings for the basic-computer control path: opcodes, bus sources,
// ALU codes, sequencer states and register-reference bit positions.
package basic_computer_pkg;

  localparam int T_W   = 3;
  localparam int BUS_W = 3;
  localparam int ALU_W = 2;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_LDA  = 3'd2;
  localparam logic [2:0] OP_STA  = 3'd3;
  localparam logic [2:0] OP_BUN  = 3'd4;
  localparam logic [2:0] OP_BSA  = 3'd5;
  localparam logic [2:0] OP_ISZ  = 3'd6;
  localparam logic [2:0] OP_RREF = 3'd7;

  localparam logic [BUS_W-1:0] BUS_NONE = 3'd0;
  localparam logic [BUS_W-1:0] BUS_AR   = 3'd1;
  localparam logic [BUS_W-1:0] BUS_PC   = 3'd2;
  localparam logic [BUS_W-1:0] BUS_DR   = 3'd3;
  localparam logic [BUS_W-1:0] BUS_AC   = 3'd4;
  localparam logic [BUS_W-1:0] BUS_IR   = 3'd5;
  localparam logic [BUS_W-1:0] BUS_MEM  = 3'd7;

  localparam logic [ALU_W-1:0] ALU_AND     = 2'd0;
  localparam logic [ALU_W-1:0] ALU_ADD     = 2'd1;
  localparam logic [ALU_W-1:0] ALU_PASS_DR = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int RR_HLT = 0;
  localparam int RR_INC = 1;
  localparam int RR_CLA = 2;
  localparam int RR_SZA = 3;

  function automatic logic [ALU_W-1:0] alu_for_op(input logic [2:0] op);
    case (op)
      OP_AND:  return ALU_AND;
      OP_ADD:  return ALU_ADD;
      default: return ALU_PASS_DR;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control/status bundle between the instruction sequencer (master) and the
// register/memory/ALU datapath (slave).
interface instr_sequencer_if
  import basic_computer_pkg::*;
#(
  parameter int DATA_W = 16
);
  logic              en;
  logic [DATA_W-1:0] ir_odat;
  logic              dr_zero;
  logic              ac_zero;
  logic              ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc;
  logic              ir_ld, ac_ld, ac_inc, ac_clr;
  logic              mem_rd, mem_wr;
  logic [BUS_W-1:0]  bus_sel;
  logic [ALU_W-1:0]  alu_code;
  logic [T_W-1:0]    sc;
  logic              running, halted;

  modport master (
    input  en, ir_odat, dr_zero, ac_zero,
    output ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ir_ld, ac_ld, ac_inc,
           ac_clr, mem_rd, mem_wr, bus_sel, alu_code, sc, running, halted
  );

  modport slave (
    output en, ir_odat, dr_zero, ac_zero,
    input  ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ir_ld, ac_ld, ac_inc,
           ac_clr, mem_rd, mem_wr, bus_sel, alu_code, sc, running, halted
  );
endinterface

// File: rtl/instr_sequencer_seq_counter.sv
// 3-bit timing counter (T index) with synchronous clear and increment.
module seq_counter
  import basic_computer_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           i_clr,
  input  logic           i_inc,
  output logic [T_W-1:0] o_count
);

  logic [T_W-1:0] r_count;

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset)     r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_inc) r_count <= r_count + 3'd1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-cycle controller: steps T0..T6 through fetch, decode, indirect
// and execute, issuing one-cycle register/memory strobes to the datapath.
module instr_sequencer
  import basic_computer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.master bus
);

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [2:0]     r_opcode;
  logic           r_ind;
  logic [3:0]     r_rr;
  logic           r_ind_done;
  logic [T_W-1:0] w_t;
  logic           w_run, w_rref, w_ind_cycle, w_halt, w_end, w_clr, w_inc;
  logic           w_unused_ir;

  seq_counter u_seq_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_count (w_t)
  );

  assign w_run  = (r_state == ST_RUN);
  assign w_rref = (r_opcode == OP_RREF);
  // An indirect instruction spends two cycles at T3: the address read first,
  // then the same empty slot a direct instruction sees.
  assign w_ind_cycle = w_run && (w_t == 3'd3) && !w_rref && r_ind && !r_ind_done;
  assign w_halt      = w_run && (w_t == 3'd3) && w_rref && r_rr[RR_HLT];

  always_comb begin
    w_end = 1'b0;
    if (w_run) begin
      case (w_t)
        3'd3:    w_end = w_rref && !r_rr[RR_HLT];
        3'd4:    w_end = (r_opcode == OP_STA) || (r_opcode == OP_BUN);
        3'd5:    w_end = (r_opcode == OP_AND) || (r_opcode == OP_ADD) ||
                         (r_opcode == OP_LDA) || (r_opcode == OP_BSA);
        3'd6:    w_end = (r_opcode == OP_ISZ);
        default: w_end = 1'b0;
      endcase
    end
  end

  assign w_clr = w_end || w_halt;
  assign w_inc = w_run && !w_clr && !w_ind_cycle;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.en) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_halt)                w_state_nxt = ST_HALT;
        else if (w_end && !bus.en) w_state_nxt = ST_IDLE;
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_opcode   <= OP_AND;
      r_ind      <= 1'b0;
      r_rr       <= '0;
      r_ind_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ind_done <= w_ind_cycle;
      if (w_run && (w_t == 3'd2)) begin
        r_opcode <= bus.ir_odat[DATA_W-2 -: 3];
        r_ind    <= bus.ir_odat[DATA_W-1];
        r_rr     <= bus.ir_odat[3:0];
      end
    end
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    {bus.ar_ld, bus.ar_inc, bus.pc_ld, bus.pc_inc, bus.dr_ld, bus.dr_inc} = '0;
    {bus.ir_ld, bus.ac_ld, bus.ac_inc, bus.ac_clr, bus.mem_rd, bus.mem_wr} = '0;
    bus.bus_sel  = BUS_NONE;
    bus.alu_code = ALU_AND;
    if (w_run) begin
      case (w_t)
        3'd0: begin bus.bus_sel = BUS_PC; bus.ar_ld = 1'b1; end
        3'd1: begin
          bus.bus_sel = BUS_MEM; bus.mem_rd = 1'b1; bus.ir_ld = 1'b1; bus.pc_inc = 1'b1;
        end
        3'd2: begin bus.bus_sel = BUS_IR; bus.ar_ld = 1'b1; end
        3'd3: begin
          if (w_rref) begin
            bus.ac_clr = r_rr[RR_CLA];
            bus.ac_inc = r_rr[RR_INC] && !r_rr[RR_CLA];
            bus.pc_inc = r_rr[RR_SZA] && bus.ac_zero;
          end else if (w_ind_cycle) begin
            bus.bus_sel = BUS_MEM; bus.mem_rd = 1'b1; bus.ar_ld = 1'b1;
          end
        end
        3'd4: begin
          case (r_opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus.bus_sel = BUS_MEM; bus.mem_rd = 1'b1; bus.dr_ld = 1'b1;
            end
            OP_STA:  begin bus.bus_sel = BUS_AC; bus.mem_wr = 1'b1; end
            OP_BUN:  begin bus.bus_sel = BUS_AR; bus.pc_ld = 1'b1; end
            OP_BSA:  begin bus.bus_sel = BUS_PC; bus.mem_wr = 1'b1; bus.ar_inc = 1'b1; end
            default: ;
          endcase
        end
        3'd5: begin
          case (r_opcode)
            OP_AND, OP_ADD, OP_LDA: begin
              bus.ac_ld = 1'b1; bus.alu_code = alu_for_op(r_opcode);
            end
            OP_BSA:  begin bus.bus_sel = BUS_AR; bus.pc_ld = 1'b1; end
            OP_ISZ:  bus.dr_inc = 1'b1;
            default: ;
          endcase
        end
        3'd6: begin
          if (r_opcode == OP_ISZ) begin
            bus.bus_sel = BUS_DR; bus.mem_wr = 1'b1; bus.pc_inc = bus.dr_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sc      = w_run ? w_t : '0;
  assign bus.running = w_run;
  assign bus.halted  = (r_state == ST_HALT);

  // Address and unused middle bits of IR belong to the datapath, not control.
  assign w_unused_ir = ^{bus.ir_odat[DATA_W-5:ADDR_W], bus.ir_odat[ADDR_W-1:4]};

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed cases plus random instruction streams,
// compared cycle by cycle against a micro-operation sequence model.
`timescale 1ns/1ps
module tb_instr_sequencer;

  localparam logic [11:0] AR_LD  = 12'h800, AR_INC = 12'h400, PC_LD  = 12'h200;
  localparam logic [11:0] PC_INC = 12'h100, DR_LD  = 12'h080, DR_INC = 12'h040;
  localparam logic [11:0] IR_LD  = 12'h020, AC_LD  = 12'h010, AC_INC = 12'h008;
  localparam logic [11:0] AC_CLR = 12'h004, MEM_RD = 12'h002, MEM_WR = 12'h001;
  localparam logic [2:0]  B_NONE = 3'd0, B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3;
  localparam logic [2:0]  B_AC = 3'd4, B_IR = 3'd5, B_MEM = 3'd7;

  typedef struct packed {
    logic [11:0] strb;
    logic [2:0]  bus;
    logic [1:0]  alu;
    logic [2:0]  sc;
    logic        running;
    logic        halted;
  } cyc_t;

  localparam cyc_t C_IDLE = '{strb: 12'h0, bus: 3'd0, alu: 2'd0, sc: 3'd0, running: 1'b0, halted: 1'b0};
  localparam cyc_t C_HALT = '{strb: 12'h0, bus: 3'd0, alu: 2'd0, sc: 3'd0, running: 1'b0, halted: 1'b1};

  logic        clk = 1'b0;
  logic        reset;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] cur_ir = 16'h0;
  cyc_t        exp_q[$];

  always #5 clk = ~clk;

  instr_sequencer_if #(.DATA_W(16)) u_if ();

  instr_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s ir=%04h: got %0h, expected %0h", tag, cur_ir, obs, exp);
  endtask

  task automatic check_cycle(input cyc_t e);
    check("strobes", 32'({u_if.ar_ld, u_if.ar_inc, u_if.pc_ld, u_if.pc_inc, u_if.dr_ld,
                          u_if.dr_inc, u_if.ir_ld, u_if.ac_ld, u_if.ac_inc, u_if.ac_clr,
                          u_if.mem_rd, u_if.mem_wr}), 32'(e.strb));
    check("bus_sel", 32'(u_if.bus_sel), 32'(e.bus));
    check("alu_code", 32'(u_if.alu_code), 32'(e.alu));
    check("sc", 32'(u_if.sc), 32'(e.sc));
    check("status", 32'({u_if.running, u_if.halted}), 32'({e.running, e.halted}));
  endtask

  function automatic cyc_t mk(input int t, input logic [11:0] s, input logic [2:0] b,
                              input logic [1:0] a);
    cyc_t c;
    c.strb = s; c.bus = b; c.alu = a; c.sc = 3'(t); c.running = 1'b1; c.halted = 1'b0;
    return c;
  endfunction

  // Micro-operation list for one instruction, one entry per clock cycle.
  function automatic void build_seq(input logic [15:0] ir, input bit acz, input bit drz,
                                    output bit halts);
    logic [2:0]  op;
    logic [11:0] s;
    op = ir[14:12];
    halts = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(0, AR_LD, B_PC, 2'd0));
    exp_q.push_back(mk(1, MEM_RD | IR_LD | PC_INC, B_MEM, 2'd0));
    exp_q.push_back(mk(2, AR_LD, B_IR, 2'd0));
    if (op == 3'd7) begin
      s = 12'h0;
      if (ir[2]) s |= AC_CLR;
      else if (ir[1]) s |= AC_INC;
      if (ir[3] && acz) s |= PC_INC;
      exp_q.push_back(mk(3, s, B_NONE, 2'd0));
      halts = ir[0];
    end else begin
      if (ir[15]) exp_q.push_back(mk(3, MEM_RD | AR_LD, B_MEM, 2'd0));
      exp_q.push_back(mk(3, 12'h0, B_NONE, 2'd0));
      case (op)
        3'd0, 3'd1, 3'd2: begin
          exp_q.push_back(mk(4, MEM_RD | DR_LD, B_MEM, 2'd0));
          exp_q.push_back(mk(5, AC_LD, B_NONE, (op == 3'd0) ? 2'd0 : (op == 3'd1) ? 2'd1 : 2'd2));
        end
        3'd3: exp_q.push_back(mk(4, MEM_WR, B_AC, 2'd0));
        3'd4: exp_q.push_back(mk(4, PC_LD, B_AR, 2'd0));
        3'd5: begin
          exp_q.push_back(mk(4, MEM_WR | AR_INC, B_PC, 2'd0));
          exp_q.push_back(mk(5, PC_LD, B_AR, 2'd0));
        end
        default: begin
          exp_q.push_back(mk(4, MEM_RD | DR_LD, B_MEM, 2'd0));
          exp_q.push_back(mk(5, DR_INC, B_NONE, 2'd0));
          exp_q.push_back(mk(6, MEM_WR | (drz ? PC_INC : 12'h0), B_DR, 2'd0));
        end
      endcase
    end
  endfunction

  function automatic int cpi_of(input logic [15:0] ir);
    case (ir[14:12])
      3'd7:       return 4;
      3'd3, 3'd4: return 5 + int'(ir[15]);
      3'd6:       return 7 + int'(ir[15]);
      default:    return 6 + int'(ir[15]);
    endcase
  endfunction

  // Starts in T0; en is random mid-instruction and en_after on the last cycle.
  task automatic run_instr(input logic [15:0] ir, input bit acz, input bit drz,
                           input bit en_after, input int abort_at, output bit halts);
    int n;
    build_seq(ir, acz, drz, halts);
    cur_ir = ir;
    u_if.ir_odat = ir; u_if.ac_zero = acz; u_if.dr_zero = drz;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      u_if.en = (i == n - 1) ? en_after : 1'($urandom);
      check_cycle(exp_q[i]);
      if (i == abort_at) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        u_if.en = 1'b0;
        return;
      end
      step();
    end
  endtask

  task automatic measure_cpi(input logic [15:0] ir);
    int cyc;
    cur_ir = ir;
    u_if.ir_odat = ir; u_if.en = 1'b1;
    u_if.ac_zero = 1'($urandom); u_if.dr_zero = 1'($urandom);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(u_if.running && u_if.sc == 3'd0) && cyc < 20);
    check("cpi", 32'(cyc), 32'(cpi_of(ir)));
  endtask

  task automatic leave_idle();
    u_if.en = 1'b1;
    check_cycle(C_IDLE);
    step();
  endtask

  task automatic halt_then_reset(input int n);
    repeat (n) begin
      u_if.en = 1'($urandom);
      check_cycle(C_HALT);
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    u_if.en = 1'b0;
  endtask

  task automatic random_phase(input int n);
    logic [15:0] ir;
    bit ea, h;
    int k;
    for (int i = 0; i < n; i++) begin
      ir = 16'($urandom);
      if (ir[14:12] == 3'd7 && ir[0] && $urandom_range(0, 3) != 0) ir[0] = 1'b0;
      ea = ($urandom_range(0, 4) != 0);
      run_instr(ir, 1'($urandom), 1'($urandom), ea, -1, h);
      if (h) begin
        halt_then_reset(int'($urandom_range(1, 4)));
      end else if (!ea) begin
        k = int'($urandom_range(1, 3));
        repeat (k) begin check_cycle(C_IDLE); step(); end
      end
      if (h || !ea) leave_idle();
    end
  endtask

  initial begin
    bit h;
    reset = 1'b0;
    u_if.en = 1'b0; u_if.ir_odat = 16'h0; u_if.ac_zero = 1'b0; u_if.dr_zero = 1'b0;
    step();
    step();
    check_cycle(C_IDLE);
    reset = 1'b1;
    repeat (2) begin step(); check_cycle(C_IDLE); end
    leave_idle();

    run_instr(16'h1042, 1'b0, 1'b0, 1'b1, -1, h);
    run_instr(16'h9010, 1'b0, 1'b0, 1'b1, -1, h);
    run_instr(16'h6020, 1'b0, 1'b1, 1'b1, -1, h);
    run_instr(16'h6020, 1'b1, 1'b0, 1'b1, -1, h);
    run_instr(16'h700C, 1'b1, 1'b0, 1'b1, -1, h);
    run_instr(16'h7006, 1'b0, 1'b1, 1'b1, -1, h);

    for (int op = 0; op < 8; op++)
      for (int ind = 0; ind < 2; ind++)
        measure_cpi({1'(ind), 3'(op), 12'h002});

    run_instr(16'h6020, 1'b0, 1'b1, 1'b1, 5, h);
    repeat (3) begin check_cycle(C_IDLE); step(); end
    leave_idle();

    run_instr(16'h7001, 1'b0, 1'b0, 1'b1, -1, h);
    halt_then_reset(6);
    leave_idle();

    random_phase(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
